imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00400000; byte address of instruction word 0.
REQ-002 Parameter DEPTH, default 1024; maximum number of words per load.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a load session; sampled only in IDLE.
REQ-006 len_words  input  11  number of words to load; sampled with start.
REQ-007 abort  input  1  terminate the session immediately.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_data  input  8  incoming image byte; the first byte of each word is the MSB.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 wena  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 waddr  output  32  write byte address, BASE_ADDR + 4*word_index.
REQ-013 wdata  output  32  assembled instruction word.
REQ-014 cpu_hold  output  1  holds the CPU in reset while loading.
REQ-015 busy  output  1  session in progress.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 error  output  1  sticky failure flag; cleared by the next accepted start or by rst.
REQ-018 checksum  output  32  XOR of all words written in the current session.

Function
REQ-019 The FSM SHALL use the states IDLE, COLLECT, WRITE and DONE.
REQ-020 IDLE: start=1 and 1<=len_words<=DEPTH -> latch len, clear word_index, byte_cnt, checksum and error, then go to COLLECT.
REQ-021 IDLE: start=1 with len_words=0 or len_words>DEPTH -> set error, stay IDLE, no write.
REQ-022 A byte SHALL be accepted only on a cycle where byte_ready=1 and byte_valid=1.
REQ-023 byte_ready SHALL be 1 only in COLLECT.
REQ-024 Accepted bytes SHALL shift into a word register MSB-first; byte_cnt increments modulo 4.
REQ-025 On the 4th accepted byte the FSM SHALL go to WRITE; wena=1 on the next cycle (latency 1 from the last byte).
REQ-026 WRITE: wena=1 for exactly one cycle with waddr=BASE_ADDR+{word_index,2'b00} and wdata=the assembled word; checksum ^= wdata.
REQ-027 WRITE: word_index+1==len -> DONE; otherwise word_index increments and the FSM returns to COLLECT.
REQ-028 DONE: done=1 for one cycle, then IDLE.
REQ-029 busy=1 and cpu_hold=1 in COLLECT, WRITE and DONE; both SHALL be 0 in IDLE.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 abort=1 in COLLECT or WRITE -> IDLE next cycle, error=1, no wena that cycle, partial word discarded, done not pulsed; abort has priority over byte acceptance and writes.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 byte_valid without byte_ready SHALL be ignored; gaps in byte_valid only stretch COLLECT.
REQ-034 word_index SHALL never exceed DEPTH-1; waddr SHALL never wrap past BASE_ADDR+4*(DEPTH-1).
REQ-035 wena, waddr and wdata SHALL be registered outputs; waddr and wdata hold their last values when wena=0.

Reset
REQ-036 rst=1 SHALL force IDLE on the next edge, including mid-session, with no write issued in that cycle.
REQ-037 Reset values SHALL be: byte_ready=0, wena=0, waddr=BASE_ADDR, wdata=0, cpu_hold=0, busy=0, done=0, error=0, checksum=0, word_index=0, byte_cnt=0.

Verification
REQ-038 Basic load: start with len=2, bytes 8'h20,08,00,05,8'h00,00,00,0C, one per cycle. Required: wena at waddr=0x00400000 with wdata=0x20080005, then wena at 0x00400004 with 0x0000000C; done pulses once; checksum=0x20080009.
REQ-039 Byte gaps: the same stream with byte_valid toggling 1/0. Required: identical writes and checksum; wena exactly 1 cycle after each 4th byte.
REQ-040 Bad length: start with len=0, then with len=1025. Required: error=1 both times, busy=0, no wena; a subsequent start with len=1 clears error.
REQ-041 Abort: abort after 6 bytes of a len=3 load. Required: one write at 0x00400000 only; error=1; busy=0 on the next cycle; no done.
REQ-042 Reset mid-session: rst during WRITE. Required: no wena that cycle; all outputs at REQ-037 values on the next cycle.
REQ-043 Full depth: len=1024 with an incrementing word pattern. Required: last write at 0x00400FFC; done pulses once; start pulses during the session are ignored.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: assembles an MSB-first byte stream into 32-bit
// words, writes them from BASE_ADDR upward and holds the CPU in reset meanwhile.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] len_words,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wena,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [10:0]       len;
  logic [IDX_W-1:0]  word_index;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sr;
  logic [31:0]       next_word;
  logic              len_ok;
  logic              last_word;

  assign next_word = {word_sr, byte_data};
  assign len_ok    = (len_words != '0) && (32'(len_words) <= DEPTH);
  assign last_word = (32'(word_index) + 32'd1) == 32'(len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      word_sr    <= '0;
      byte_ready <= 1'b0;
      wena       <= 1'b0;
      waddr      <= BASE_ADDR;
      wdata      <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
    end else begin
      wena <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len        <= len_words;
              word_index <= '0;
              byte_cnt   <= '0;
              checksum   <= '0;
              error      <= 1'b0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              state      <= COLLECT;
            end else begin
              error <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (abort) begin
            error      <= 1'b1;
            byte_cnt   <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            state      <= IDLE;
          end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= next_word[23:0];
            // The write strobe is issued on the same edge that takes the 4th
            // byte, so wena is high for exactly the cycle spent in WRITE.
            if (byte_cnt == 2'd3) begin
              wena       <= 1'b1;
              waddr      <= BASE_ADDR + 32'({word_index, 2'b00});
              wdata      <= next_word;
              checksum   <= checksum ^ next_word;
              byte_ready <= 1'b0;
              state      <= WRITE;
            end
          end
        end

        WRITE: begin
          if (abort) begin
            error    <= 1'b1;
            byte_cnt <= '0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= IDLE;
          end else if (last_word) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            word_index <= word_index + 1'b1;
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end

        DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and matched (address, data, cycle) when wena appears.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] len_words = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wena, cpu_hold, busy, done, error;
  logic [31:0] waddr, wdata, checksum;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wena(wena), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] chk_model;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wena) begin
      if (sb.size() == 0) begin
        check("spurious_wena", 32'(wena), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
        check("wena_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap, output int acc);
    int t = 0;
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    acc = cyc;
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit gap);
    int   acc;
    exp_t e;
    logic [31:0] tmp;
    tmp = w;
    for (int unsigned b = 0; b < 4; b++) begin
      send_byte(tmp[31:24], gap, acc);
      tmp = tmp << 8;
    end
    e.addr = BASE + 32'(idx) * 32'd4;
    e.data = w;
    e.cyc  = acc + 1;
    sb.push_back(e);
    chk_model ^= w;
  endtask

  task automatic do_start(input logic [10:0] len);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    len_words  = len;
    @(negedge clk);
    start = 1'b0;
    chk_model = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wena"}, 32'(wena), 32'd0);
    check({tag, "_waddr"}, waddr, BASE);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int acc;
    logic [31:0] basic [2];
    basic[0] = 32'h2008_0005;
    basic[1] = 32'h0000_000C;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Basic load, one byte per cycle, then the same stream with gaps.
    for (int g = 0; g < 2; g++) begin
      d0 = done_cnt;
      do_start(11'd2);
      check("busy_after_start", 32'(busy), 32'd1);
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      check("ready_after_start", 32'(byte_ready), 32'd1);
      for (int i = 0; i < 2; i++) send_word(i, basic[i], g[0]);
      wait_idle();
      check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("basic_checksum", checksum, 32'h2008_0009);
      check("basic_checksum_model", checksum, chk_model);
      check("basic_error", 32'(error), 32'd0);
      check("basic_hold_idle", 32'(cpu_hold), 32'd0);
    end

    // Bad lengths.
    do_start(11'd0);
    check("len0_error", 32'(error), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    do_start(11'd1025);
    check("len1025_error", 32'(error), 32'd1);
    check("len1025_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    do_start(11'd1);
    check("len1_error_cleared", 32'(error), 32'd0);
    check("len1_checksum_cleared", checksum, 32'd0);
    send_word(0, 32'hDEAD_BEEF, 1'b0);
    wait_idle();
    check("len1_checksum", checksum, 32'hDEAD_BEEF);

    // Abort after 6 bytes of a 3-word load; abort beats a valid byte.
    d0 = done_cnt;
    do_start(11'd3);
    send_word(0, 32'h1122_3344, 1'b0);
    send_byte(8'h55, 1'b0, acc);
    send_byte(8'h66, 1'b0, acc);
    @(negedge clk);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    @(negedge clk);
    abort      = 1'b0;
    byte_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_error", 32'(error), 32'd1);
    check("abort_ready", 32'(byte_ready), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Reset while in WRITE.
    do_start(11'd2);
    send_word(0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // Full depth with ignored start pulses.
    d0 = done_cnt;
    do_start(11'd1024);
    for (int k = 0; k < 1024; k++) begin
      if (k == 300 || k == 700) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        len_words  = 11'd5;
        @(negedge clk);
        start = 1'b0;
        check("busy_during_start", 32'(busy), 32'd1);
      end
      send_word(k, 32'h1000_0000 + 32'(k), 1'b0);
    end
    wait_idle();
    check("full_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("full_last_waddr", waddr, 32'h0040_0FFC);
    check("full_checksum", checksum, chk_model);
    check("full_error", 32'(error), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
